// File: rtl/sdio_crc16_mlane_if.sv
// Bus bundle between the SD data-path controller and the multi-lane CRC16 engine.
// With SDIO_CRC_ERR_INJ_EN defined the bundle also carries err_inj.
interface sdio_crc16_mlane_if #(
  parameter int LANES = 8,
  parameter int CNT_W = 13
);
  logic [1:0]          bus_width;
  logic                mode_tx;
  logic                start;
  logic                abort;
  logic [CNT_W-1:0]    blk_len;
  logic                bit_en;
  logic [LANES-1:0]    din;
  logic                busy;
  logic                crc_phase;
  logic [LANES-1:0]    crc_dout;
  logic                done;
  logic                crc_err;
  logic [LANES-1:0]    err_lane;
  logic [16*LANES-1:0] crc_val;
`ifdef SDIO_CRC_ERR_INJ_EN
  logic                err_inj;

  modport master (
    output bus_width, mode_tx, start, abort, blk_len, bit_en, din, err_inj,
    input  busy, crc_phase, crc_dout, done, crc_err, err_lane, crc_val
  );
  modport slave (
    input  bus_width, mode_tx, start, abort, blk_len, bit_en, din, err_inj,
    output busy, crc_phase, crc_dout, done, crc_err, err_lane, crc_val
  );
`else
  modport master (
    output bus_width, mode_tx, start, abort, blk_len, bit_en, din,
    input  busy, crc_phase, crc_dout, done, crc_err, err_lane, crc_val
  );
  modport slave (
    input  bus_width, mode_tx, start, abort, blk_len, bit_en, din,
    output busy, crc_phase, crc_dout, done, crc_err, err_lane, crc_val
  );
`endif
endinterface

// File: rtl/sdio_crc16_mlane.sv
// Per-lane SD data CRC16 (x^16+x^12+x^5+1) engine sequencing DATA -> CRC -> DONE.
// Optional TX error injection on lane 0's final CRC bit: define SDIO_CRC_ERR_INJ_EN.
module sdio_crc16_mlane #(
  parameter int LANES = 8,
  parameter int CNT_W = 13
) (
  input  logic                 sd_clk,
  input  logic                 rstn,
  input  logic                 sd_rst,
  sdio_crc16_mlane_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_CRC  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                  state_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic [CNT_W-1:0]        blk_len_reg;
  logic [1:0]              bw_reg;
  logic                    mode_tx_reg;
  logic [LANES-1:0][15:0]  crc_reg;
  logic [LANES-1:0][15:0]  crc_data_next;
  logic [LANES-1:0][15:0]  crc_shift;
  logic [LANES-1:0]        lane_act;
  logic [LANES-1:0]        rx_miss;
  logic [LANES-1:0]        err_lane_reg;
  logic [LANES-1:0]        err_next;
  logic [LANES-1:0]        crc_dout_w;
  logic [LANES-1:0]        inj_vec;
  logic                    busy_reg;
  logic                    crc_phase_reg;
  logic                    done_reg;
  logic                    crc_err_reg;
  logic [3:0]              n_act;
  logic                    last_data;
  logic                    last_crc;

  // Lane count from the latched bus width, clamped to what is implemented.
  always_comb begin
    case (bw_reg)
      2'd1:    n_act = 4'd4;
      2'd2:    n_act = 4'd8;
      default: n_act = 4'd1;
    endcase
    if (n_act > 4'(LANES)) begin
      n_act = 4'(LANES);
    end
  end

  assign last_data = bus.bit_en && (cnt_reg == blk_len_reg - CNT_W'(1));
  assign last_crc  = bus.bit_en && (cnt_reg == CNT_W'(15));

`ifdef SDIO_CRC_ERR_INJ_EN
  logic inj_reg;

  always_ff @(posedge sd_clk or negedge rstn) begin
    if (!rstn) begin
      inj_reg <= 1'b0;
    end else if (sd_rst) begin
      inj_reg <= 1'b0;
    end else if (!bus.abort && state_reg == ST_IDLE && bus.start) begin
      inj_reg <= bus.err_inj;
    end
  end

  // Only lane 0, only the 16th CRC bit, only when transmitting.
  always_comb begin
    inj_vec    = '0;
    inj_vec[0] = inj_reg && mode_tx_reg && (cnt_reg == CNT_W'(15));
  end
`else
  assign inj_vec = '0;
`endif

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic fb;

      assign lane_act[gi] = (n_act > 4'(gi));
      assign fb           = crc_reg[gi][15] ^ bus.din[gi];

      // Inactive lanes keep their CRC at the cleared value.
      assign crc_data_next[gi] = lane_act[gi]
                               ? {crc_reg[gi][14:12], crc_reg[gi][11] ^ fb, crc_reg[gi][10:5],
                                  crc_reg[gi][4] ^ fb, crc_reg[gi][3:0], fb}
                               : crc_reg[gi];
      assign crc_shift[gi]     = {crc_reg[gi][14:0], 1'b0};
      assign rx_miss[gi]       = lane_act[gi] & (bus.din[gi] ^ crc_reg[gi][15]);
      assign crc_dout_w[gi]    = crc_phase_reg & mode_tx_reg & lane_act[gi]
                               & (crc_reg[gi][15] ^ inj_vec[gi]);
      assign bus.crc_val[16*gi +: 16] = crc_reg[gi];
    end
  endgenerate

  assign err_next = err_lane_reg | (mode_tx_reg ? '0 : rx_miss);

  always_ff @(posedge sd_clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      blk_len_reg   <= '0;
      bw_reg        <= '0;
      mode_tx_reg   <= 1'b0;
      crc_reg       <= '0;
      err_lane_reg  <= '0;
      busy_reg      <= 1'b0;
      crc_phase_reg <= 1'b0;
      done_reg      <= 1'b0;
      crc_err_reg   <= 1'b0;
    end else if (sd_rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      blk_len_reg   <= '0;
      bw_reg        <= '0;
      mode_tx_reg   <= 1'b0;
      crc_reg       <= '0;
      err_lane_reg  <= '0;
      busy_reg      <= 1'b0;
      crc_phase_reg <= 1'b0;
      done_reg      <= 1'b0;
      crc_err_reg   <= 1'b0;
    end else if (bus.abort) begin
      // Error flags survive an abort so firmware can still inspect them.
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      crc_reg       <= '0;
      busy_reg      <= 1'b0;
      crc_phase_reg <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            crc_reg      <= '0;
            cnt_reg      <= '0;
            err_lane_reg <= '0;
            crc_err_reg  <= 1'b0;
            mode_tx_reg  <= bus.mode_tx;
            blk_len_reg  <= bus.blk_len;
            bw_reg       <= bus.bus_width;
            busy_reg     <= 1'b1;
            if (bus.blk_len == '0) begin
              state_reg     <= ST_CRC;
              crc_phase_reg <= 1'b1;
            end else begin
              state_reg <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (bus.bit_en) begin
            crc_reg <= crc_data_next;
            if (last_data) begin
              cnt_reg       <= '0;
              state_reg     <= ST_CRC;
              crc_phase_reg <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
        end
        ST_CRC: begin
          if (bus.bit_en) begin
            crc_reg      <= crc_shift;
            err_lane_reg <= err_next;
            if (last_crc) begin
              cnt_reg       <= '0;
              state_reg     <= ST_DONE;
              busy_reg      <= 1'b0;
              crc_phase_reg <= 1'b0;
              done_reg      <= 1'b1;
              crc_err_reg   <= |err_next;
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_reg;
  assign bus.crc_phase = crc_phase_reg;
  assign bus.crc_dout  = crc_dout_w;
  assign bus.done      = done_reg;
  assign bus.crc_err   = crc_err_reg;
  assign bus.err_lane  = err_lane_reg;

endmodule

// File: tb/tb_sdio_crc16_mlane.sv
// Randomised bench for sdio_crc16_mlane: block-level reference model compared every cycle,
// plus literal expectations (0x7FA1 reference CRC, latency, error lanes).
module tb_sdio_crc16_mlane;
  localparam int LANES  = 8;
  localparam int CNT_W  = 13;
  localparam int P_IDLE = 0;
  localparam int P_DATA = 1;
  localparam int P_CRC  = 2;
  localparam int P_DONE = 3;

  logic sd_clk = 1'b0;
  logic rstn   = 1'b0;
  logic sd_rst = 1'b0;

  sdio_crc16_mlane_if #(.LANES(LANES), .CNT_W(CNT_W)) bus ();

  sdio_crc16_mlane #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .sd_clk (sd_clk),
    .rstn   (rstn),
    .sd_rst (sd_rst),
    .bus    (bus)
  );

  always #5 sd_clk = ~sd_clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: phase, bit counter, per-lane CRC words.
  int               m_phase = P_IDLE;
  int               m_cnt   = 0;
  int               m_blk   = 0;
  int               m_n     = 1;
  bit               m_tx    = 1'b0;
  bit               m_inj   = 1'b0;
  bit               m_done  = 1'b0;
  bit               m_crc_err = 1'b0;
  logic [15:0]      m_crc [LANES];
  logic [LANES-1:0] m_err = '0;

  logic [15:0] tx_bits;
  logic [15:0] first_val;
  int          done_k;
  bit          blk_inj;

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic d);
    logic [15:0] r;
    r = {c[14:0], 1'b0};
    if (c[15] ^ d) r = r ^ 16'h1021;
    return r;
  endfunction

  function automatic int lanes_for(input logic [1:0] bw);
    int n;
    n = (bw == 2'd1) ? 4 : (bw == 2'd2) ? 8 : 1;
    return (n > LANES) ? LANES : n;
  endfunction

  function automatic logic [LANES-1:0] get_din(input int pat, input int idx);
    if (pat == 0) return '1;
    if (pat == 1) return LANES'($urandom);
    return LANES'((idx * 53) ^ 8'hA6);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE; m_cnt = 0; m_blk = 0; m_n = 1; m_tx = 0; m_inj = 0;
    m_done = 0; m_crc_err = 0; m_err = '0;
    for (int i = 0; i < LANES; i++) m_crc[i] = 16'h0;
  endtask

  task automatic model_step();
    if (!rstn || sd_rst) begin
      model_reset();
      return;
    end
    m_done = 1'b0;
    if (bus.abort) begin
      m_phase = P_IDLE; m_cnt = 0;
      for (int i = 0; i < LANES; i++) m_crc[i] = 16'h0;
      return;
    end
    case (m_phase)
      P_IDLE: if (bus.start) begin
        for (int i = 0; i < LANES; i++) m_crc[i] = 16'h0;
        m_err = '0; m_crc_err = 0; m_cnt = 0;
        m_tx  = bus.mode_tx;
        m_blk = int'(bus.blk_len);
        m_n   = lanes_for(bus.bus_width);
`ifdef SDIO_CRC_ERR_INJ_EN
        m_inj = bus.err_inj;
`else
        m_inj = 1'b0;
`endif
        m_phase = (m_blk == 0) ? P_CRC : P_DATA;
      end
      P_DATA: if (bus.bit_en) begin
        for (int i = 0; i < m_n; i++) m_crc[i] = crc_upd(m_crc[i], bus.din[i]);
        m_cnt++;
        if (m_cnt == m_blk) begin m_cnt = 0; m_phase = P_CRC; end
      end
      P_CRC: if (bus.bit_en) begin
        if (!m_tx)
          for (int i = 0; i < m_n; i++) if (bus.din[i] != m_crc[i][15]) m_err[i] = 1'b1;
        for (int i = 0; i < LANES; i++) m_crc[i] = {m_crc[i][14:0], 1'b0};
        m_cnt++;
        if (m_cnt == 16) begin
          m_cnt = 0; m_phase = P_DONE; m_done = 1'b1; m_crc_err = |m_err;
        end
      end
      default: m_phase = P_IDLE;
    endcase
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge sd_clk);
      model_step();
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial begin
    logic [16*LANES-1:0] exp_val;
    logic [LANES-1:0]    exp_dout;
    forever begin
      @(negedge sd_clk);
      exp_val  = '0;
      exp_dout = '0;
      for (int i = 0; i < LANES; i++) begin
        exp_val[16*i +: 16] = m_crc[i];
        if (m_phase == P_CRC && m_tx && i < m_n)
          exp_dout[i] = m_crc[i][15] ^ (i == 0 && m_inj && m_cnt == 15);
      end
      chk("busy",      128'(bus.busy),      128'(m_phase == P_DATA || m_phase == P_CRC));
      chk("crc_phase", 128'(bus.crc_phase), 128'(m_phase == P_CRC));
      chk("done",      128'(bus.done),      128'(m_done));
      chk("crc_err",   128'(bus.crc_err),   128'(m_crc_err));
      chk("err_lane",  128'(bus.err_lane),  128'(m_err));
      chk("crc_dout",  128'(bus.crc_dout),  128'(exp_dout));
      chk("crc_val",   128'(bus.crc_val),   128'(exp_val));
    end
  end

  task automatic run_block(input string name, input logic [1:0] bw, input bit tx, input int blen,
                           input int pat, input int en_pat, input logic [LANES-1:0] corrupt,
                           input int corrupt_at, input int abort_at, input bit noise,
                           input bit use_lit, input logic [15:0] lit0);
    int k, idx;
    bit aborted, rst_hit, got_first, en;
    logic [15:0] e0;
    logic [LANES-1:0] d;
    tx_bits = '0; first_val = '0; done_k = -1; e0 = '0; idx = 0;
    aborted = 0; rst_hit = 0; got_first = 0;
    bus.start = 1'b1; bus.bus_width = bw; bus.mode_tx = tx; bus.blk_len = CNT_W'(blen);
    blk_inj = noise ? 1'($urandom % 2) : 1'b0;
`ifdef SDIO_CRC_ERR_INJ_EN
    bus.err_inj = blk_inj;
`else
    blk_inj = 1'b0;
`endif
    k = 0;
    forever begin
      @(posedge sd_clk);
      #1;
      k++;
      bus.start = 1'b0; bus.abort = 1'b0; sd_rst = 1'b0; bus.bit_en = 1'b0;
      if (bus.done && done_k < 0) done_k = k;
      if (m_phase == P_CRC && m_cnt == 0 && !got_first) begin
        first_val = bus.crc_val[15:0];
        got_first = 1;
      end
      if (m_phase == P_IDLE) break;
      if (k > 20000) begin
        checks++; errors++;
        $display("FAIL timeout %s actual=busy required=idle", name);
        break;
      end
      en = (en_pat == 0) ? 1'b1 : (en_pat == 1) ? 1'(k % 2) : 1'($urandom % 4 != 0);
      bus.bit_en = en;
      d = LANES'($urandom);
      if (m_phase == P_DATA) begin
        d = get_din(pat, idx);
        if (en) begin e0 = crc_upd(e0, d[0]); idx++; end
      end else if (m_phase == P_CRC) begin
        if (!tx) begin
          for (int i = 0; i < m_n; i++)
            d[i] = m_crc[i][15] ^ (corrupt[i] && m_cnt == corrupt_at);
          if (use_lit) d[0] = lit0[15 - m_cnt];
        end
        if (tx && en) tx_bits = {tx_bits[14:0], bus.crc_dout[0]};
        if (m_cnt == abort_at && !aborted) begin bus.abort = 1'b1; aborted = 1; end
      end
      if (noise) begin
        bus.start     = ($urandom % 8 == 0);
        bus.mode_tx   = 1'($urandom);
        bus.bus_width = 2'($urandom);
        bus.blk_len   = CNT_W'($urandom);
        if (m_phase == P_DATA && $urandom % 200 == 0) begin bus.abort = 1'b1; aborted = 1; end
        if ($urandom % 400 == 0) begin sd_rst = 1'b1; rst_hit = 1; end
      end
      bus.din = d;
    end
    bus.start = 1'b0; bus.abort = 1'b0; sd_rst = 1'b0; bus.bit_en = 1'b0;
    if (!aborted && !rst_hit) begin
      chk({name, "_done_seen"}, 128'(done_k >= 0), 128'(1));
      if (tx) chk({name, "_tx_crc0"}, 128'(tx_bits), 128'(e0 ^ {15'h0, blk_inj}));
    end
    $display("BLK %s bw=%0d tx=%0d len=%0d done_k=%0d err_lane=%h crc_err=%0d",
             name, bw, tx, blen, done_k, bus.err_lane, bus.crc_err);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    bus.bus_width = 2'd0; bus.mode_tx = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
    bus.blk_len = '0; bus.bit_en = 1'b0; bus.din = '0;
`ifdef SDIO_CRC_ERR_INJ_EN
    bus.err_inj = 1'b0;
`endif
    repeat (3) @(posedge sd_clk);
    #1;
    chk("reset_crc_val", 128'(bus.crc_val), 128'(0));
    chk("reset_busy",    128'(bus.busy),    128'(0));
    rstn = 1'b1;
    repeat (2) @(posedge sd_clk);
    #1;

    // 512 bytes of 0xFF on one lane: well-known CRC 0x7FA1.
    run_block("tx1_ones", 2'd0, 1'b1, 4096, 0, 0, '0, 0, -1, 1'b0, 1'b0, 16'h0);
    chk("tx1_serial",  128'(tx_bits),    128'(16'h7FA1));
    chk("tx1_crc_val", 128'(first_val),  128'(16'h7FA1));
    chk("tx1_latency", 128'(done_k + 1), 128'(4114));

    run_block("rx1_good", 2'd0, 1'b0, 4096, 0, 0, '0, 0, -1, 1'b0, 1'b1, 16'h7FA1);
    chk("rx1_good_err_lane", 128'(bus.err_lane), 128'(0));
    chk("rx1_good_crc_err",  128'(bus.crc_err),  128'(0));

    run_block("rx1_bad", 2'd3, 1'b0, 4096, 0, 0, '0, 0, -1, 1'b0, 1'b1, 16'h7FA0);
    chk("rx1_bad_err_lane", 128'(bus.err_lane), 128'(8'h01));
    chk("rx1_bad_crc_err",  128'(bus.crc_err),  128'(1));

    run_block("rx4_lane2", 2'd1, 1'b0, 8, 1, 0, 8'h04, 7, -1, 1'b0, 1'b0, 16'h0);
    chk("rx4_err_lane", 128'(bus.err_lane), 128'(8'h04));
    chk("rx4_crc_err",  128'(bus.crc_err),  128'(1));

    run_block("tx8_nostall", 2'd2, 1'b1, 4, 2, 0, '0, 0, -1, 1'b0, 1'b0, 16'h0);
    run_block("tx8_stall",   2'd2, 1'b1, 4, 2, 1, '0, 0, -1, 1'b0, 1'b0, 16'h0);

    run_block("tx_abort", 2'd1, 1'b1, 6, 1, 0, '0, 0, 5, 1'b0, 1'b0, 16'h0);
    chk("abort_no_done", 128'(done_k),      128'(-1));
    chk("abort_busy",    128'(bus.busy),    128'(0));
    chk("abort_crc_val", 128'(bus.crc_val), 128'(0));
    run_block("after_abort", 2'd1, 1'b0, 6, 1, 0, '0, 0, -1, 1'b0, 1'b0, 16'h0);
    chk("after_abort_err", 128'(bus.err_lane), 128'(0));

    run_block("tx_len0", 2'd2, 1'b1, 0, 1, 0, '0, 0, -1, 1'b0, 1'b0, 16'h0);
    chk("len0_serial",  128'(tx_bits),    128'(0));
    chk("len0_latency", 128'(done_k + 1), 128'(18));

    for (int b = 0; b < 60; b++) begin
      run_block("rand", 2'($urandom), 1'($urandom), int'($urandom_range(0, 24)), 1, 2,
                LANES'($urandom), int'($urandom_range(0, 15)),
                ($urandom % 6 == 0) ? int'($urandom_range(0, 15)) : -1,
                1'b1, 1'b0, 16'h0);
      repeat ($urandom_range(0, 2)) @(posedge sd_clk);
      #1;
    end

    repeat (3) @(posedge sd_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
